// File: rtl/arcade_pkg.sv
// Shared types for the arcade sprite controllers: FSM states, coordinate type, gravity limit.
package arcade_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FREEZE} motion_state_t;

    localparam int GRAVITY_VMAX = 8;

    typedef logic [31:0] coord_t;

endpackage

// File: rtl/axis_bounce.sv
// One-axis step with clamp-and-reverse at 0 and at i_max; purely combinational.
module axis_bounce
    import arcade_pkg::*;
(
    input  coord_t i_pos,
    input  coord_t i_step,
    input  coord_t i_max,
    input  logic   i_dir,
    output coord_t o_pos,
    output logic   o_dir
);

    // Compare before subtracting so the position never wraps below zero.
    always_comb begin
        o_pos = i_pos;
        o_dir = i_dir;
        if (!i_dir) begin
            if (i_pos + i_step >= i_max) begin
                o_pos = i_max;
                o_dir = 1'b1;
            end else begin
                o_pos = i_pos + i_step;
            end
        end else begin
            if (i_pos <= i_step) begin
                o_pos = '0;
                o_dir = 1'b0;
            end else begin
                o_pos = i_pos - i_step;
            end
        end
    end

endmodule

// File: rtl/ghost_motion_ctrl.sv
// Per-frame sprite motion: bounce off screen edges, freeze after a collision.
// Optional macro GHOST_GRAVITY_EN replaces the constant vertical bounce with a signed vy.
module ghost_motion_ctrl
    import arcade_pkg::*;
#(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned OBJ_W      = 64,
    parameter int unsigned OBJ_H      = 64,
    parameter int unsigned INIT_X     = 288,
    parameter int unsigned INIT_Y     = 208,
    parameter int unsigned SPEED_X    = 2,
    parameter int unsigned SPEED_Y    = 1,
    parameter int unsigned HIT_FRAMES = 30
) (
    input  logic   clk,
    input  logic   resetN,
    input  logic   i_startOfFrame,
    input  logic   i_enable,
    input  logic   i_collision,
    output coord_t o_topLeft_x,
    output coord_t o_topLeft_y,
    output logic   o_x_direction,
    output logic   o_y_direction,
    output logic   o_frozen,
    output logic   o_hit_pulse
);

    localparam coord_t X_MAX = coord_t'(SCREEN_W - OBJ_W);
    localparam coord_t Y_MAX = coord_t'(SCREEN_H - OBJ_H);

    motion_state_t r_state, w_state_d;
    coord_t        r_x, w_x_d, r_y, w_y_d, r_cnt, w_cnt_d;
    logic          r_xdir, w_xdir_d, r_latch, w_latch_d, r_frozen, r_hit, w_hit_d;
    coord_t        w_x_mv, w_y_mv;
    logic          w_xdir_mv;

    axis_bounce u_axis_x (
        .i_pos  (r_x),
        .i_step (coord_t'(SPEED_X)),
        .i_max  (X_MAX),
        .i_dir  (r_xdir),
        .o_pos  (w_x_mv),
        .o_dir  (w_xdir_mv)
    );

`ifdef GHOST_GRAVITY_EN
    logic signed [7:0]  r_vy, w_vy_d, w_vy_inc, w_vy_mv;
    logic signed [33:0] w_ysum;

    assign w_vy_inc = (r_vy >= 8'(GRAVITY_VMAX)) ? 8'(GRAVITY_VMAX) : r_vy + 8'sd1;
    assign w_ysum   = $signed({2'b00, r_y}) + $signed({{26{w_vy_inc[7]}}, w_vy_inc});

    always_comb begin
        w_y_mv  = w_ysum[31:0];
        w_vy_mv = w_vy_inc;
        if (w_ysum >= $signed({2'b00, Y_MAX})) begin
            w_y_mv  = Y_MAX;
            w_vy_mv = -w_vy_inc;
        end else if (w_ysum <= 34'sd0) begin
            w_y_mv  = '0;
            w_vy_mv = '0;
        end
    end

    assign o_y_direction = r_vy[7];
`else
    logic r_ydir, w_ydir_d, w_ydir_mv;

    axis_bounce u_axis_y (
        .i_pos  (r_y),
        .i_step (coord_t'(SPEED_Y)),
        .i_max  (Y_MAX),
        .i_dir  (r_ydir),
        .o_pos  (w_y_mv),
        .o_dir  (w_ydir_mv)
    );

    assign o_y_direction = r_ydir;
`endif

    always_comb begin
        w_state_d = r_state;
        w_x_d     = r_x;
        w_y_d     = r_y;
        w_xdir_d  = r_xdir;
        w_cnt_d   = r_cnt;
        w_hit_d   = 1'b0;
`ifdef GHOST_GRAVITY_EN
        w_vy_d    = r_vy;
`else
        w_ydir_d  = r_ydir;
`endif
        // The latch is consumed (or discarded) by every SOF tick, whatever the state.
        w_latch_d = i_startOfFrame ? 1'b0 : (r_latch | i_collision);
        if (i_startOfFrame) begin
            unique case (r_state)
                IDLE: if (i_enable) w_state_d = RUN;
                RUN: begin
                    if (!i_enable) begin
                        w_state_d = IDLE;
                    end else if (r_latch | i_collision) begin
                        w_state_d = FREEZE;
                        w_cnt_d   = coord_t'(HIT_FRAMES - 1);
                        w_hit_d   = 1'b1;
                        w_xdir_d  = ~r_xdir;
                    end else begin
                        w_x_d    = w_x_mv;
                        w_xdir_d = w_xdir_mv;
                        w_y_d    = w_y_mv;
`ifdef GHOST_GRAVITY_EN
                        w_vy_d   = w_vy_mv;
`else
                        w_ydir_d = w_ydir_mv;
`endif
                    end
                end
                FREEZE: begin
                    if (r_cnt == '0) w_state_d = RUN;
                    else             w_cnt_d   = r_cnt - 1'b1;
                end
                default: w_state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= IDLE;
            r_x      <= coord_t'(INIT_X);
            r_y      <= coord_t'(INIT_Y);
            r_xdir   <= 1'b0;
            r_cnt    <= '0;
            r_latch  <= 1'b0;
            r_frozen <= 1'b0;
            r_hit    <= 1'b0;
`ifdef GHOST_GRAVITY_EN
            r_vy     <= '0;
`else
            r_ydir   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_d;
            r_x      <= w_x_d;
            r_y      <= w_y_d;
            r_xdir   <= w_xdir_d;
            r_cnt    <= w_cnt_d;
            r_latch  <= w_latch_d;
            r_frozen <= (w_state_d == FREEZE);
            r_hit    <= w_hit_d;
`ifdef GHOST_GRAVITY_EN
            r_vy     <= w_vy_d;
`else
            r_ydir   <= w_ydir_d;
`endif
        end
    end

    assign o_topLeft_x   = r_x;
    assign o_topLeft_y   = r_y;
    assign o_x_direction = r_xdir;
    assign o_frozen      = r_frozen;
    assign o_hit_pulse   = r_hit;

endmodule
